lpf_movavg: RTL and testbench
=============================

// Module: lpf_movavg
// PURPOSE
//  Parametrised moving-average low-pass filter over a power-of-two window (2**LOG2_DEPTH samples).
//  Uses a circular sample buffer and a running-sum accumulator (one add, one subtract per sample).
//  Samples are accepted on a valid strobe rather than on every clock.
//  Adds optional rounding, a window-full flag and a synchronous flush sequence.
//  Sits between ADC/measurement capture and the hybrid-control law, filtering sensed signals.
// PARAMETERS
//  NBIT        32  width of input sample and output mean, signed two's complement
//  LOG2_DEPTH  5   window depth D = 2**LOG2_DEPTH; legal range 1..8
//  ROUND       0   0 = truncate (floor, arithmetic shift); 1 = add 2**(LOG2_DEPTH-1) before shift
// PORTS
//  i_clock    in   1     clock, all logic on rising edge
//  i_RESET    in   1     reset, asynchronous, active-low
//  i_clear    in   1     synchronous flush request, sampled on rising edge
//  i_valid    in   1     sample strobe; i_data accepted on edges where high and o_busy low
//  i_data     in   NBIT  signed input sample
//  o_mean     out  NBIT  signed windowed mean, registered
//  o_valid    out  1     one-cycle pulse: o_mean holds a newly computed value
//  o_full     out  1     high once D samples accepted since last reset/flush
//  o_busy     out  1     high during FLUSH; samples are dropped
// BEHAVIOUR
//  Reset (async, i_RESET=0):
//   - buffer, acc, wp, cnt, o_mean cleared to 0; o_valid=0, o_full=0, o_busy=0
//   - state=FILL
//  Storage:
//   - buf[0..D-1] NBIT signed; write pointer wp LOG2_DEPTH bits, wraps D-1 -> 0
//   - cnt counts accepted samples, 0..D, saturates at D
//   - acc signed, NBIT+LOG2_DEPTH bits (sign-extend all operands): no overflow possible
//  Accept edge (i_valid=1, o_busy=0, i_clear=0), edge k:
//   - acc <= acc + i_data - buf[wp]; buf[wp] <= i_data; wp <= wp+1
//   - evicted entry is 0 while not yet written -> partial sum during FILL
//  Output, edge k+1:
//   - o_mean <= (acc + (ROUND ? 2**(LOG2_DEPTH-1) : 0)) >>> LOG2_DEPTH, truncated to NBIT
//   - o_valid high for exactly the cycle after edge k+1
//   - latency: i_valid edge to o_valid edge = 2 clocks
//   - back-to-back i_valid every clock gives one o_valid per sample, in order
//   - o_mean holds its value between updates
//  States:
//   - FILL: cnt<D, o_full=0; o_mean = sum/D (zeros counted), not divided by cnt
//     FILL -> RUN when cnt reaches D (the D-th accept); o_full rises same edge
//   - RUN: o_full=1; oldest sample evicted on each accept
//   - FLUSH: o_busy=1; writes buf[wp]<=0, wp++ each clock, D clocks; i_valid ignored
//     FLUSH -> FILL after writing buf[D-1]; wp=0, o_busy falls
//  i_clear=1 in any state (incl. FLUSH, restarts it):
//   - enter FLUSH at wp=0; acc, cnt, o_mean <= 0; o_full <= 0
//   - pending o_valid for an in-flight sample suppressed
//  Simultaneous i_clear and i_valid: clear wins, sample dropped
//  Rounding cannot overflow: all-max input yields max, all-min yields min
//  Reset mid-operation (any state incl. FLUSH): immediate return to reset values
// TESTING (D=4, NBIT=32 unless stated)
//  1 Step: reset, i_data=100 with i_valid 4 consecutive clocks
//    -> o_mean 25,50,75,100 on 4 o_valid pulses, 2 clocks latency
//    -> o_full rises with 4th accept
//  2 Wrap/evict: after test 1, feed 200 once
//    -> o_mean 125; wp back to 1; o_full stays 1
//  3 Rounding: from reset, 4 samples of -2
//    -> ROUND=0: o_mean -1,-1,-2,-2; ROUND=1: 0,-1,-1,-2
//  4 Extremes: 4x 32'h7FFFFFFF -> final o_mean 32'h7FFFFFFF
//    -> then 4x 32'h80000000 -> final o_mean 32'h80000000; no wrap either ROUND
//  5 Flush: in RUN assert i_clear 1 clock with i_valid=1
//    -> o_busy high 4 clocks, o_mean=0, o_full=0, no o_valid
//    -> i_valid during busy ignored; next sample 8 gives o_mean 2
//  6 Sparse strobes + async reset: i_valid every 3rd clock, 1,2,3
//    -> o_mean 0,0,1 (ROUND=0)
//    -> i_RESET low mid-FLUSH clears all outputs immediately, state FILL

Source files
------------

// File: rtl/lpf_movavg.sv
// lpf_movavg: moving-average low-pass filter over a 2**LOG2_DEPTH sample window.
//   Circular sample buffer plus running-sum accumulator (one add, one subtract per
//   accepted sample); optional round-half-up, window-full flag, synchronous flush.
// Ports:
//   i_clock  - clock, rising edge          i_RESET - async reset, active low
//   i_clear  - synchronous flush request   i_valid - sample strobe (ignored while o_busy)
//   i_data   - signed input sample         o_mean  - registered signed window mean
//   o_valid  - one-cycle pulse, new o_mean o_full  - D samples seen since reset/flush
//   o_busy   - flush in progress, input samples dropped
module lpf_movavg #(
  parameter int NBIT       = 32,
  parameter int LOG2_DEPTH = 5,
  parameter int ROUND      = 0
) (
  input  logic            i_clock,
  input  logic            i_RESET,
  input  logic            i_clear,
  input  logic            i_valid,
  input  logic [NBIT-1:0] i_data,
  output logic [NBIT-1:0] o_mean,
  output logic            o_valid,
  output logic            o_full,
  output logic            o_busy
);

  localparam int D  = 1 << LOG2_DEPTH;
  localparam int AW = NBIT + LOG2_DEPTH;  // D * sample range always fits

  localparam logic [LOG2_DEPTH:0]   CNT_LAST = (LOG2_DEPTH+1)'(D - 1);
  localparam logic [LOG2_DEPTH:0]   CNT_MAX  = (LOG2_DEPTH+1)'(D);
  localparam logic [LOG2_DEPTH-1:0] WP_LAST  = {LOG2_DEPTH{1'b1}};

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [NBIT-1:0]        sbuf [D];
  logic [LOG2_DEPTH-1:0]  wp;
  logic [LOG2_DEPTH:0]    cnt;
  logic signed [AW-1:0]   acc;
  logic signed [AW-1:0]   acc_nxt;
  logic signed [AW-1:0]   acc_rnd;
  logic [NBIT-1:0]        mean_sh;
  logic                   pend;     // sample accepted last edge, mean due this edge
  logic                   accept;

  assign o_busy = (state == FLUSH);
  assign o_full = (state == RUN);
  assign accept = i_valid && !o_busy && !i_clear;

  // Entry about to be overwritten is the oldest sample (or a zero during FILL),
  // so the sum is updated without re-adding the window.
  assign acc_nxt = acc + AW'($signed(i_data)) - AW'($signed(sbuf[wp]));

  // Bias of D/2 gives round-half-up; the sum has LOG2_DEPTH bits of headroom
  // beyond the extremes, so the bias can never wrap.
  always_comb begin
    acc_rnd = acc;
    if (ROUND != 0) acc_rnd = acc + (AW'(1) << (LOG2_DEPTH - 1));
  end

  assign mean_sh = NBIT'(acc_rnd >>> LOG2_DEPTH);

  // State register
  always_ff @(posedge i_clock or negedge i_RESET) begin
    if (!i_RESET) state <= FILL;
    else          state <= state_nxt;
  end

  // Next-state logic; clear overrides everything, including a running flush
  always_comb begin
    state_nxt = state;
    if (i_clear) begin
      state_nxt = FLUSH;
    end else begin
      case (state)
        FILL:    if (accept && cnt == CNT_LAST) state_nxt = RUN;
        RUN:     state_nxt = RUN;
        FLUSH:   if (wp == WP_LAST) state_nxt = FILL;
        default: state_nxt = FILL;
      endcase
    end
  end

  // Datapath: buffer, pointer, running sum, output register
  always_ff @(posedge i_clock or negedge i_RESET) begin
    if (!i_RESET) begin
      for (int i = 0; i < D; i++) sbuf[i] <= '0;
      wp      <= '0;
      cnt     <= '0;
      acc     <= '0;
      pend    <= 1'b0;
      o_mean  <= '0;
      o_valid <= 1'b0;
    end else if (i_clear) begin
      // Flush starts at slot 0; any mean still in flight is discarded.
      wp      <= '0;
      cnt     <= '0;
      acc     <= '0;
      pend    <= 1'b0;
      o_mean  <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= pend;
      if (pend) o_mean <= mean_sh;
      pend <= accept;
      if (state == FLUSH) begin
        sbuf[wp] <= '0;
        wp       <= wp + 1'b1;
      end else if (accept) begin
        sbuf[wp] <= i_data;
        wp       <= wp + 1'b1;
        acc      <= acc_nxt;
        if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lpf_movavg.sv
module tb_lpf_movavg;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        valid;
  logic [31:0] data;

  logic [31:0] mean0, mean1;
  logic        valid0, valid1, full0, full1, busy0, busy1;

  int n_cmp = 0;
  int n_err = 0;

  // Same stimulus to a truncating and a rounding instance, D = 4
  lpf_movavg #(.NBIT(32), .LOG2_DEPTH(2), .ROUND(0)) dut0 (
    .i_clock(clk), .i_RESET(rst_n), .i_clear(clear), .i_valid(valid), .i_data(data),
    .o_mean(mean0), .o_valid(valid0), .o_full(full0), .o_busy(busy0)
  );

  lpf_movavg #(.NBIT(32), .LOG2_DEPTH(2), .ROUND(1)) dut1 (
    .i_clock(clk), .i_RESET(rst_n), .i_clear(clear), .i_valid(valid), .i_data(data),
    .o_mean(mean1), .o_valid(valid1), .o_full(full1), .o_busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear = 1'b0;
    valid = 1'b0;
    data  = '0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({mean0, mean1} !== 64'd0) begin
      n_err++; $display("FAIL reset_mean got %h/%h exp 0", mean0, mean1);
    end
    n_cmp++;
    if ({valid0, valid1, full0, full1, busy0, busy1} !== 6'b0) begin
      n_err++; $display("FAIL reset_flags got v%b%b f%b%b b%b%b exp all 0",
                        valid0, valid1, full0, full1, busy0, busy1);
    end
  endtask

  // 100 on four consecutive clocks: means 25,50,75,100, two clocks latency
  task automatic test_step();
    logic ev;
    do_reset();
    valid = 1'b1;
    data  = 32'd100;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 4) valid = 1'b0;
      ev = (i >= 2 && i <= 5);
      n_cmp++;
      if ({valid0, valid1} !== {ev, ev}) begin
        n_err++; $display("FAIL step_valid edge=%0d got %b/%b exp %b", i, valid0, valid1, ev);
      end
      if (ev) begin
        n_cmp++;
        if ({mean0, mean1} !== {32'(25 * (i - 1)), 32'(25 * (i - 1))}) begin
          n_err++; $display("FAIL step_mean edge=%0d got %0d/%0d exp %0d",
                            i, mean0, mean1, 25 * (i - 1));
        end
      end
      n_cmp++;
      if ({full0, full1} !== {2{i >= 4}}) begin
        n_err++; $display("FAIL step_full edge=%0d got %b/%b exp %b", i, full0, full1, i >= 4);
      end
    end
  endtask

  // Continues from test_step: 200 evicts one 100 -> 125
  task automatic test_wrap();
    valid = 1'b1;
    data  = 32'd200;
    tick();
    valid = 1'b0;
    n_cmp++;
    if (dut0.wp !== 2'd1) begin
      n_err++; $display("FAIL wrap_wp got %0d exp 1", dut0.wp);
    end
    n_cmp++;
    if ({valid0, valid1} !== 2'b00) begin
      n_err++; $display("FAIL wrap_early_valid got %b/%b exp 0", valid0, valid1);
    end
    tick();
    n_cmp++;
    if ({valid0, valid1} !== 2'b11) begin
      n_err++; $display("FAIL wrap_valid got %b/%b exp 1", valid0, valid1);
    end
    n_cmp++;
    if ({mean0, mean1} !== {32'd125, 32'd125}) begin
      n_err++; $display("FAIL wrap_mean got %0d/%0d exp 125", mean0, mean1);
    end
    n_cmp++;
    if ({full0, full1} !== 2'b11) begin
      n_err++; $display("FAIL wrap_full got %b/%b exp 1", full0, full1);
    end
  endtask

  // Four samples of -2: truncation -1,-1,-2,-2; rounding 0,-1,-1,-2
  task automatic test_round();
    int e0 [4];
    int e1 [4];
    e0 = '{-1, -1, -2, -2};
    e1 = '{0, -1, -1, -2};
    do_reset();
    valid = 1'b1;
    data  = 32'hFFFF_FFFE;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 4) valid = 1'b0;
      if (i >= 2) begin
        n_cmp++;
        if ({valid0, valid1} !== 2'b11) begin
          n_err++; $display("FAIL round_valid edge=%0d got %b/%b exp 1", i, valid0, valid1);
        end
        n_cmp++;
        if (mean0 !== 32'(e0[i-2])) begin
          n_err++; $display("FAIL round_trunc_mean edge=%0d got %0d exp %0d",
                            i, $signed(mean0), e0[i-2]);
        end
        n_cmp++;
        if (mean1 !== 32'(e1[i-2])) begin
          n_err++; $display("FAIL round_up_mean edge=%0d got %0d exp %0d",
                            i, $signed(mean1), e1[i-2]);
        end
      end
    end
  endtask

  // Full-scale inputs must not wrap in either rounding mode
  task automatic test_extremes();
    do_reset();
    valid = 1'b1;
    data  = 32'h7FFF_FFFF;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 4) data = 32'h8000_0000;
      if (i == 8) valid = 1'b0;
      if (i == 5) begin
        n_cmp++;
        if ({mean0, mean1} !== {32'h7FFF_FFFF, 32'h7FFF_FFFF}) begin
          n_err++; $display("FAIL extreme_max got %h/%h exp 7fffffff", mean0, mean1);
        end
      end
      if (i == 6) begin
        n_cmp++;
        if ({mean0, mean1} !== {32'h3FFF_FFFF, 32'h3FFF_FFFF}) begin
          n_err++; $display("FAIL extreme_mix got %h/%h exp 3fffffff", mean0, mean1);
        end
      end
      if (i == 9) begin
        n_cmp++;
        if ({mean0, mean1} !== {32'h8000_0000, 32'h8000_0000}) begin
          n_err++; $display("FAIL extreme_min got %h/%h exp 80000000", mean0, mean1);
        end
      end
    end
  endtask

  // Clear with a coincident sample and an in-flight mean, then flush for 4 clocks
  task automatic test_flush();
    do_reset();
    valid = 1'b1;
    data  = 32'd40;
    repeat (4) tick();
    n_cmp++;
    if ({full0, full1} !== 2'b11) begin
      n_err++; $display("FAIL flush_pre_full got %b/%b exp 1", full0, full1);
    end
    clear = 1'b1;
    data  = 32'd1000;
    tick();
    clear = 1'b0;
    n_cmp++;
    if ({busy0, busy1, full0, full1, valid0, valid1} !== 6'b110000) begin
      n_err++; $display("FAIL flush_enter got b%b%b f%b%b v%b%b exp b11 f00 v00",
                        busy0, busy1, full0, full1, valid0, valid1);
    end
    n_cmp++;
    if ({mean0, mean1} !== 64'd0) begin
      n_err++; $display("FAIL flush_mean got %0d/%0d exp 0", mean0, mean1);
    end
    for (int j = 1; j <= 4; j++) begin
      tick();
      n_cmp++;
      if ({busy0, busy1} !== {2{j < 4}}) begin
        n_err++; $display("FAIL flush_busy cycle=%0d got %b/%b exp %b", j, busy0, busy1, j < 4);
      end
      n_cmp++;
      if ({valid0, valid1} !== 2'b00) begin
        n_err++; $display("FAIL flush_novalid cycle=%0d got %b/%b exp 0", j, valid0, valid1);
      end
    end
    data = 32'd8;
    tick();
    valid = 1'b0;
    n_cmp++;
    if ({valid0, valid1} !== 2'b00) begin
      n_err++; $display("FAIL flush_dropped got %b/%b exp 0", valid0, valid1);
    end
    tick();
    n_cmp++;
    if ({valid0, valid1} !== 2'b11) begin
      n_err++; $display("FAIL flush_after_valid got %b/%b exp 1", valid0, valid1);
    end
    n_cmp++;
    if ({mean0, mean1} !== {32'd2, 32'd2}) begin
      n_err++; $display("FAIL flush_after_mean got %0d/%0d exp 2", mean0, mean1);
    end
  endtask

  // Strobes every third clock, then async reset in the middle of a flush
  task automatic test_sparse_reset();
    int e0 [3];
    int e1 [3];
    e0 = '{0, 0, 1};
    e1 = '{0, 1, 2};
    do_reset();
    for (int s = 0; s < 3; s++) begin
      valid = 1'b1;
      data  = 32'(s + 1);
      tick();
      valid = 1'b0;
      n_cmp++;
      if ({valid0, valid1} !== 2'b00) begin
        n_err++; $display("FAIL sparse_early sample=%0d got %b/%b exp 0", s, valid0, valid1);
      end
      tick();
      n_cmp++;
      if ({valid0, valid1} !== 2'b11) begin
        n_err++; $display("FAIL sparse_valid sample=%0d got %b/%b exp 1", s, valid0, valid1);
      end
      n_cmp++;
      if ({mean0, mean1} !== {32'(e0[s]), 32'(e1[s])}) begin
        n_err++; $display("FAIL sparse_mean sample=%0d got %0d/%0d exp %0d/%0d",
                          s, mean0, mean1, e0[s], e1[s]);
      end
      tick();
      n_cmp++;
      if ({valid0, valid1} !== 2'b00) begin
        n_err++; $display("FAIL sparse_pulse sample=%0d got %b/%b exp 0", s, valid0, valid1);
      end
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    n_cmp++;
    if ({busy0, busy1} !== 2'b11) begin
      n_err++; $display("FAIL midflush_busy got %b/%b exp 1", busy0, busy1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy0, busy1, full0, full1, valid0, valid1} !== 6'b0) begin
      n_err++; $display("FAIL midflush_reset got b%b%b f%b%b v%b%b exp all 0",
                        busy0, busy1, full0, full1, valid0, valid1);
    end
    n_cmp++;
    if ({dut0.wp, dut1.wp} !== 4'b0) begin
      n_err++; $display("FAIL midflush_wp got %0d/%0d exp 0", dut0.wp, dut1.wp);
    end
    tick();
    rst_n = 1'b1;
    n_cmp++;
    if ({busy0, busy1} !== 2'b00) begin
      n_err++; $display("FAIL postreset_busy got %b/%b exp 0", busy0, busy1);
    end
    valid = 1'b1;
    data  = 32'd12;
    tick();
    valid = 1'b0;
    tick();
    n_cmp++;
    if ({valid0, valid1, full0, full1} !== 4'b1100) begin
      n_err++; $display("FAIL postreset_fill got v%b%b f%b%b exp v11 f00",
                        valid0, valid1, full0, full1);
    end
    n_cmp++;
    if ({mean0, mean1} !== {32'd3, 32'd3}) begin
      n_err++; $display("FAIL postreset_mean got %0d/%0d exp 3", mean0, mean1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clear = 1'b0;
    valid = 1'b0;
    data  = '0;
    test_reset();
    test_step();
    test_wrap();
    test_round();
    test_extremes();
    test_flush();
    test_sparse_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
